// File: rtl/fetch.sv
// fetch -- instruction fetch stage with a 2-entry output buffer.
//
// Requests one word at a time from instruction memory (ic_req held until
// ic_ack), buffers {pc, instruction} pairs in a small FIFO toward decode, and
// handles redirects (pc_reload) that may arrive while a request is in flight.
//
// Ports
//   clk_in          system clock, rising edge
//   reset_in        synchronous active-high reset
//   cpu_halt        block new memory requests (outstanding one still completes)
//   pc_reload       redirect fetch, flushes buffer
//   pc_reload_addr  redirect target, bits [1:0] ignored
//   ic_req/ic_addr  memory request and word address
//   ic_ack          memory response valid, data on ic_rd_data
//   f2d_valid/rdy   handshake toward decode
//   f2d_instr/pc    buffer head, zero when f2d_valid=0
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        cpu_halt,
  input  logic        pc_reload,
  input  logic [31:0] pc_reload_addr,
  output logic        ic_req,
  output logic [31:0] ic_addr,
  input  logic        ic_ack,
  input  logic [31:0] ic_rd_data,
  output logic        f2d_valid,
  input  logic        f2d_rdy,
  output logic [31:0] f2d_instr,
  output logic [31:0] f2d_pc
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [1:0]  count_q;
  logic [1:0]  count_d;
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [31:0] buf_pc_q    [2];
  logic [31:0] buf_instr_q [2];

  logic [31:0] reload_tgt;
  logic        push;
  logic        pop;

  assign reload_tgt = pc_reload_addr & ~32'd3;
  assign push       = (state_q == WAIT) && ic_ack && !pc_reload;
  assign pop        = f2d_valid && f2d_rdy;

  // Occupancy after this cycle's push/pop, ignoring flush; also used to
  // decide whether WAIT can issue the next request back to back.
  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  assign ic_req    = (state_q == WAIT) || (state_q == DISCARD);
  assign ic_addr   = pc_q;
  assign f2d_valid = (count_q != 2'd0);
  assign f2d_instr = f2d_valid ? buf_instr_q[rd_ptr_q] : 32'd0;
  assign f2d_pc    = f2d_valid ? buf_pc_q[rd_ptr_q]    : 32'd0;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC & ~32'd3;
      tgt_q    <= 32'd0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      assert (!(push && count_q == FULL));

      case (state_q)
        IDLE: begin
          if (pc_reload) begin
            pc_q <= reload_tgt;
          end else if (!cpu_halt && count_q < FULL) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (pc_reload) begin
            if (ic_ack) begin
              pc_q    <= reload_tgt;
              state_q <= IDLE;
            end else begin
              // Keep ic_addr stable until memory answers; remember target.
              tgt_q   <= reload_tgt;
              state_q <= DISCARD;
            end
          end else if (ic_ack) begin
            pc_q <= pc_q + 32'd4;
            if (cpu_halt || count_d >= FULL) begin
              state_q <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (ic_ack) begin
            // A reload coinciding with the ack is the newest target.
            pc_q    <= pc_reload ? reload_tgt : tgt_q;
            state_q <= IDLE;
          end else if (pc_reload) begin
            tgt_q <= reload_tgt;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (pc_reload) begin
        count_q  <= 2'd0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        count_q <= count_d;
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // Buffer storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk_in) begin
    if (!reset_in && push) begin
      buf_pc_q[wr_ptr_q]    <= pc_q;
      buf_instr_q[wr_ptr_q] <= ic_rd_data;
    end
  end

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        cpu_halt;
  logic        pc_reload;
  logic [31:0] pc_reload_addr;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ack;
  logic [31:0] ic_rd_data;
  logic        f2d_valid;
  logic        f2d_rdy;
  logic [31:0] f2d_instr;
  logic [31:0] f2d_pc;

  fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .cpu_halt       (cpu_halt),
    .pc_reload      (pc_reload),
    .pc_reload_addr (pc_reload_addr),
    .ic_req         (ic_req),
    .ic_addr        (ic_addr),
    .ic_ack         (ic_ack),
    .ic_rd_data     (ic_rd_data),
    .f2d_valid      (f2d_valid),
    .f2d_rdy        (f2d_rdy),
    .f2d_instr      (f2d_instr),
    .f2d_pc         (f2d_pc)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Stimulus knobs, applied at the next negedge by step()
  logic        drv_reset  = 1'b0;
  logic        drv_halt   = 1'b0;
  logic        drv_reload = 1'b0;
  logic [31:0] drv_tgt    = 32'd0;
  logic        drv_rdy    = 1'b1;
  logic        force_ack  = 1'b0;
  int          lat        = 0;
  int          wait_cnt   = 0;

  // Reference model: expected fetch address and expected buffer contents
  logic [31:0] pc_m;
  logic        disc_m;
  logic [31:0] pend_m;
  logic [31:0] q_pc  [$];
  logic [31:0] q_ins [$];
  logic [31:0] popped [$];
  logic        prev_reset;
  logic        prev_block;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic        req_s;
    logic [31:0] addr_s;
    logic        ack;
    logic        acked;
    logic        pop;
    logic [31:0] tgt;
    @(negedge clk_in);
    req_s  = ic_req;
    addr_s = ic_addr;

    if (prev_reset) chk("req_after_reset", {31'd0, req_s}, 32'd0);
    if (prev_block) chk("halt_no_req", {31'd0, req_s}, 32'd0);
    if (req_s === 1'b1) chk("ic_addr", addr_s, pc_m);
    chk("f2d_valid", {31'd0, f2d_valid}, {31'd0, (q_pc.size() != 0)});
    if (q_pc.size() != 0) begin
      chk("f2d_pc", f2d_pc, q_pc[0]);
      chk("f2d_instr", f2d_instr, q_ins[0]);
    end else begin
      chk("f2d_pc_zero", f2d_pc, 32'd0);
      chk("f2d_instr_zero", f2d_instr, 32'd0);
    end
    chk("buf_overflow", {31'd0, (q_pc.size() <= 2)}, 32'd1);

    // Memory responder: ack after 'lat' waiting cycles, or forced
    ack = force_ack;
    if (req_s === 1'b1) begin
      if (wait_cnt >= lat) ack = 1'b1;
      else wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    if (ack) wait_cnt = 0;
    acked = ack && (req_s === 1'b1);
    pop   = (f2d_valid === 1'b1) && drv_rdy;

    ic_ack         = ack;
    ic_rd_data     = acked ? mem_data(addr_s) : $urandom;
    reset_in       = drv_reset;
    cpu_halt       = drv_halt;
    pc_reload      = drv_reload;
    pc_reload_addr = drv_tgt;
    f2d_rdy        = drv_rdy;

    // Model update for the coming edge
    tgt = drv_tgt & ~32'd3;
    if (drv_reset) begin
      q_pc.delete(); q_ins.delete();
      pc_m = RESET_PC; disc_m = 1'b0;
    end else if (drv_reload) begin
      q_pc.delete(); q_ins.delete();
      if (req_s === 1'b1 && !acked) begin
        disc_m = 1'b1; pend_m = tgt;
      end else begin
        disc_m = 1'b0; pc_m = tgt;
      end
    end else begin
      if (pop) begin
        popped.push_back(q_pc[0]);
        void'(q_pc.pop_front()); void'(q_ins.pop_front());
      end
      if (acked) begin
        if (disc_m) begin
          disc_m = 1'b0; pc_m = pend_m;
        end else begin
          q_pc.push_back(pc_m); q_ins.push_back(mem_data(pc_m));
          pc_m = pc_m + 32'd4;
        end
      end
    end
    prev_reset = drv_reset;
    prev_block = drv_halt && (req_s !== 1'b1) && !drv_reset;
  endtask

  task automatic do_reset();
    drv_reset = 1'b1; drv_reload = 1'b0; drv_halt = 1'b0; force_ack = 1'b0;
    step(); step();
    drv_reset = 1'b0;
    step();
  endtask

  initial begin
    reset_in = 1'b1; cpu_halt = 1'b0; pc_reload = 1'b0; pc_reload_addr = 32'd0;
    ic_ack = 1'b0; ic_rd_data = 32'd0; f2d_rdy = 1'b1;
    pc_m = RESET_PC; disc_m = 1'b0; pend_m = 32'd0;
    prev_reset = 1'b1; prev_block = 1'b0;
    repeat (2) @(posedge clk_in);

    // Zero-wait streaming: one address per cycle, f2d_pc one cycle behind
    lat = 0; drv_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("stream_req", {31'd0, ic_req}, 32'd1);
      chk("stream_addr", ic_addr, 32'(i * 4));
      if (i > 0) chk("stream_f2d_pc", f2d_pc, 32'((i - 1) * 4));
    end

    // Decode stalled: buffer fills with pc 0,4 and requests stop
    do_reset();
    drv_rdy = 1'b0;
    repeat (10) step();
    chk("stall_req", {31'd0, ic_req}, 32'd0);
    chk("stall_valid", {31'd0, f2d_valid}, 32'd1);
    chk("stall_head", f2d_pc, 32'd0);
    popped.delete();
    drv_rdy = 1'b1;
    repeat (6) step();
    chk("drain_cnt", {31'd0, (popped.size() >= 3)}, 32'd1);
    if (popped.size() >= 3) begin
      chk("drain_0", popped[0], 32'd0);
      chk("drain_1", popped[1], 32'd4);
      chk("drain_2", popped[2], 32'd8);
    end

    // Redirect while waiting on a slow ack
    lat = 3;
    do_reset();
    drv_reload = 1'b1; drv_tgt = 32'h0000_0103;
    step();
    drv_reload = 1'b0;
    repeat (3) step();
    lat = 0;
    begin
      int n = 0;
      step();
      while (ic_req !== 1'b1 && n < 6) begin step(); n++; end
      chk("redir_req", {31'd0, ic_req}, 32'd1);
      chk("redir_addr", ic_addr, 32'h0000_0100);
    end

    // Redirect coinciding with ack and pop while one entry is buffered
    lat = 0;
    do_reset();
    lat = 255; drv_rdy = 1'b0;
    step();
    force_ack = 1'b1; step();
    force_ack = 1'b0; step();
    chk("pre_flush_valid", {31'd0, f2d_valid}, 32'd1);
    force_ack = 1'b1; drv_rdy = 1'b1; drv_reload = 1'b1; drv_tgt = 32'h0000_0300;
    step();
    force_ack = 1'b0; drv_reload = 1'b0; lat = 0;
    step();
    chk("flush_valid", {31'd0, f2d_valid}, 32'd0);
    step();
    chk("flush_next_req", {31'd0, ic_req}, 32'd1);
    chk("flush_next_addr", ic_addr, 32'h0000_0300);

    // Reset while a request is outstanding, then a stray ack in IDLE
    lat = 0;
    do_reset();
    lat = 255;
    step();
    drv_reset = 1'b1; step();
    drv_reset = 1'b0; force_ack = 1'b1; step();
    force_ack = 1'b0; lat = 0; step();
    chk("post_reset_req", {31'd0, ic_req}, 32'd1);
    chk("post_reset_addr", ic_addr, RESET_PC);
    chk("post_reset_valid", {31'd0, f2d_valid}, 32'd0);

    // Halt during a slow request: ack still buffered, resume at PC+4
    lat = 2; drv_rdy = 1'b1;
    do_reset();
    drv_halt = 1'b1;
    repeat (8) step();
    chk("halt_idle", {31'd0, ic_req}, 32'd0);
    drv_halt = 1'b0;
    step(); step();
    chk("resume_addr", ic_addr, 32'd4);

    // Randomized traffic against the model
    lat = 1;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      drv_rdy    = ($urandom_range(0, 9) < 7);
      drv_halt   = ($urandom_range(0, 9) == 0);
      drv_reload = ($urandom_range(0, 29) == 0);
      drv_tgt    = $urandom;
      drv_reset  = ($urandom_range(0, 199) == 0);
      force_ack  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(0, 3);
      step();
    end
    drv_reset = 1'b0; drv_reload = 1'b0; force_ack = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
